// File: rtl/ym7101_vram_slot_arb_if.sv
// Request, grant and VRAM strobe bundle between the YM7101 slot arbiter and its requesters.
// The arbiter uses the master side; requesters and the VRAM pins use the slave side.
interface ym7101_vram_slot_arb_if;
    logic       render_req;
    logic       slot_blank;
    logic       fifo_req;
    logic       fifo_we;
    logic       dma_req;
    logic [3:0] gnt;
    logic       ack;
    logic       ras_n;
    logic       cas_n;
    logic       we_n;
    logic [1:0] slot_phase;

    modport master (
        input  render_req,
        input  slot_blank,
        input  fifo_req,
        input  fifo_we,
        input  dma_req,
        output gnt,
        output ack,
        output ras_n,
        output cas_n,
        output we_n,
        output slot_phase
    );

    modport slave (
        output render_req,
        output slot_blank,
        output fifo_req,
        output fifo_we,
        output dma_req,
        input  gnt,
        input  ack,
        input  ras_n,
        input  cas_n,
        input  we_n,
        input  slot_phase
    );
endinterface

// File: rtl/ym7101_vram_slot_arb.sv
// YM7101 VRAM access-slot arbiter: counts clk1/clk2 phase pulses into 4-phase slots,
// grants each slot to refresh, render, CPU FIFO or DMA and sequences RAS/CAS/WE.
module ym7101_vram_slot_arb #(
    parameter int unsigned REFRESH_PERIOD = 16
) (
    input  logic                          MCLK,
    input  logic                          rst,
    input  logic                          clk1,
    input  logic                          clk2,
    ym7101_vram_slot_arb_if.master        bus
);

    typedef enum logic [1:0] {
        PH0 = 2'd0,
        PH1 = 2'd1,
        PH2 = 2'd2,
        PH3 = 2'd3
    } phase_e;

    localparam logic [3:0] GNT_IDLE    = 4'b0000;
    localparam logic [3:0] GNT_DMA     = 4'b0001;
    localparam logic [3:0] GNT_FIFO    = 4'b0010;
    localparam logic [3:0] GNT_RENDER  = 4'b0100;
    localparam logic [3:0] GNT_REFRESH = 4'b1000;
    localparam logic [7:0] REF_LAST    = 8'(REFRESH_PERIOD - 32'd1);

    phase_e     phase_q,     phase_d;
    logic [3:0] gnt_q,       gnt_d;
    logic       ack_q,       ack_d;
    logic       ras_n_q,     ras_n_d;
    logic       cas_n_q,     cas_n_d;
    logic       we_n_q,      we_n_d;
    logic [7:0] ref_cnt_q,   ref_cnt_d;
    logic       ref_due_q,   ref_due_d;
    logic       last_dma_q,  last_dma_d;
    logic       fifo_we_q,   fifo_we_d;

    logic       step_s;
    logic       enter0_s;
    logic       enter1_s;
    logic       enter3_s;
    logic       due_now_s;
    logic [3:0] winner_s;

    // A clk2 in phase 3 is dropped so that every slot starts on a clk1 edge.
    always_comb begin
        step_s = 1'b0;
        if (clk1) begin
            step_s = 1'b1;
        end else if (clk2 && (phase_q != PH3)) begin
            step_s = 1'b1;
        end else begin
            step_s = 1'b0;
        end
        enter0_s = step_s && (phase_q == PH3);
        enter1_s = step_s && (phase_q == PH0);
        enter3_s = step_s && (phase_q == PH2);
    end

    // Phase counter next state.
    always_comb begin
        phase_d = phase_q;
        if (step_s) begin
            case (phase_q)
                PH0:     phase_d = PH1;
                PH1:     phase_d = PH2;
                PH2:     phase_d = PH3;
                PH3:     phase_d = PH0;
                default: phase_d = PH3;
            endcase
        end else begin
            phase_d = phase_q;
        end
    end

    // Refresh timer: the wrap event is visible to the same slot-boundary arbitration,
    // so refresh recurs exactly every REFRESH_PERIOD slots.
    always_comb begin
        ref_cnt_d = ref_cnt_q;
        due_now_s = ref_due_q;
        if (enter0_s) begin
            if (ref_cnt_q >= REF_LAST) begin
                ref_cnt_d = 8'd0;
                due_now_s = 1'b1;
            end else begin
                ref_cnt_d = ref_cnt_q + 8'd1;
                due_now_s = ref_due_q;
            end
        end else begin
            ref_cnt_d = ref_cnt_q;
            due_now_s = ref_due_q;
        end
    end

    // Fixed priority refresh > render > round-robin {fifo, dma}.
    always_comb begin
        winner_s = GNT_IDLE;
        if (due_now_s) begin
            winner_s = GNT_REFRESH;
        end else if (bus.render_req && !bus.slot_blank) begin
            winner_s = GNT_RENDER;
        end else if (bus.fifo_req && bus.dma_req) begin
            winner_s = last_dma_q ? GNT_FIFO : GNT_DMA;
        end else if (bus.fifo_req) begin
            winner_s = GNT_FIFO;
        end else if (bus.dma_req) begin
            winner_s = GNT_DMA;
        end else begin
            winner_s = GNT_IDLE;
        end
    end

    // Grant, strobe and acknowledge sequencing across the four phases of a slot.
    always_comb begin
        gnt_d      = gnt_q;
        ack_d      = 1'b0;
        ras_n_d    = ras_n_q;
        cas_n_d    = cas_n_q;
        we_n_d     = we_n_q;
        last_dma_d = last_dma_q;
        fifo_we_d  = fifo_we_q;
        ref_due_d  = ref_due_q;
        if (enter0_s) begin
            gnt_d     = winner_s;
            ras_n_d   = (winner_s == GNT_IDLE);
            cas_n_d   = 1'b1;
            we_n_d    = 1'b1;
            fifo_we_d = bus.fifo_we;
            ref_due_d = due_now_s && (winner_s != GNT_REFRESH);
            if (winner_s == GNT_FIFO) begin
                last_dma_d = 1'b0;
            end else if (winner_s == GNT_DMA) begin
                last_dma_d = 1'b1;
            end else begin
                last_dma_d = last_dma_q;
            end
        end else if (enter1_s) begin
            // Refresh is RAS-only; render reads, DMA always writes.
            cas_n_d = ~(gnt_q[2] | gnt_q[1] | gnt_q[0]);
            we_n_d  = ~(gnt_q[0] | (gnt_q[1] & fifo_we_q));
        end else if (enter3_s) begin
            ras_n_d = 1'b1;
            cas_n_d = 1'b1;
            we_n_d  = 1'b1;
            ack_d   = (gnt_q != GNT_IDLE);
        end else begin
            gnt_d = gnt_q;
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge MCLK) begin
        if (rst) begin
            phase_q    <= PH3;
            gnt_q      <= GNT_IDLE;
            ack_q      <= 1'b0;
            ras_n_q    <= 1'b1;
            cas_n_q    <= 1'b1;
            we_n_q     <= 1'b1;
            ref_cnt_q  <= 8'd0;
            ref_due_q  <= 1'b0;
            last_dma_q <= 1'b1;
            fifo_we_q  <= 1'b0;
        end else begin
            phase_q    <= phase_d;
            gnt_q      <= gnt_d;
            ack_q      <= ack_d;
            ras_n_q    <= ras_n_d;
            cas_n_q    <= cas_n_d;
            we_n_q     <= we_n_d;
            ref_cnt_q  <= ref_cnt_d;
            ref_due_q  <= ref_due_d;
            last_dma_q <= last_dma_d;
            fifo_we_q  <= fifo_we_d;
        end
    end

    assign bus.gnt        = gnt_q;
    assign bus.ack        = ack_q;
    assign bus.ras_n      = ras_n_q;
    assign bus.cas_n      = cas_n_q;
    assign bus.we_n       = we_n_q;
    assign bus.slot_phase = phase_q;

endmodule

// File: tb/tb_ym7101_vram_slot_arb.sv
// Directed bench for ym7101_vram_slot_arb: one instance with the default refresh period
// and one with REFRESH_PERIOD=4 for the refresh cadence.
module tb_ym7101_vram_slot_arb;

    logic mclk = 1'b0;
    logic rst  = 1'b1;
    logic clk1 = 1'b0;
    logic clk2 = 1'b0;
    logic sel4 = 1'b0;

    int check_cnt = 0;
    int error_cnt = 0;

    ym7101_vram_slot_arb_if bus16 ();
    ym7101_vram_slot_arb_if bus4 ();

    ym7101_vram_slot_arb #(.REFRESH_PERIOD(16)) u_dut16 (
        .MCLK (mclk),
        .rst  (rst),
        .clk1 (clk1),
        .clk2 (clk2),
        .bus  (bus16)
    );

    ym7101_vram_slot_arb #(.REFRESH_PERIOD(4)) u_dut4 (
        .MCLK (mclk),
        .rst  (rst),
        .clk1 (clk1),
        .clk2 (clk2),
        .bus  (bus4)
    );

    always #5 mclk = ~mclk;

    logic [3:0] o_gnt;
    logic       o_ack, o_ras_n, o_cas_n, o_we_n;
    logic [1:0] o_phase;
    assign o_gnt   = sel4 ? bus4.gnt        : bus16.gnt;
    assign o_ack   = sel4 ? bus4.ack        : bus16.ack;
    assign o_ras_n = sel4 ? bus4.ras_n      : bus16.ras_n;
    assign o_cas_n = sel4 ? bus4.cas_n      : bus16.cas_n;
    assign o_we_n  = sel4 ? bus4.we_n       : bus16.we_n;
    assign o_phase = sel4 ? bus4.slot_phase : bus16.slot_phase;

    task automatic check_eq(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        check_cnt++;
        if (obs !== exp) begin
            error_cnt++;
            $display("FAIL %s got=%0h want=%0h t=%0t", tag, obs, exp, $time);
        end
    endtask

    // One-MCLK phase pulse; returns on the following falling edge, after outputs settle.
    task automatic strobe(input logic c1, input logic c2);
        @(negedge mclk);
        clk1 = c1;
        clk2 = c2;
        @(negedge mclk);
        clk1 = 1'b0;
        clk2 = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge mclk);
        rst = 1'b1;
        @(negedge mclk);
        rst = 1'b0;
    endtask

    task automatic check_outs(input string tag, input logic [1:0] ph, input logic [3:0] g,
                              input logic ack, input logic ras_n, input logic cas_n,
                              input logic we_n);
        check_eq({tag, ".phase"}, {6'd0, o_phase}, {6'd0, ph});
        check_eq({tag, ".gnt"},   {4'd0, o_gnt},   {4'd0, g});
        check_eq({tag, ".ack"},   {7'd0, o_ack},   {7'd0, ack});
        check_eq({tag, ".ras_n"}, {7'd0, o_ras_n}, {7'd0, ras_n});
        check_eq({tag, ".cas_n"}, {7'd0, o_cas_n}, {7'd0, cas_n});
        check_eq({tag, ".we_n"},  {7'd0, o_we_n},  {7'd0, we_n});
    endtask

    // Full slot clk1,clk2,clk1,clk2 from phase 3; we_act says whether we_n drops in phases 1-2.
    task automatic run_slot(input string tag, input logic [3:0] g, input logic we_act);
        logic act;
        logic cas_act;
        act     = (g != 4'b0000);
        cas_act = (g[2:0] != 3'b000);
        strobe(1'b1, 1'b0);
        check_outs({tag, "/p0"}, 2'd0, g, 1'b0, ~act, 1'b1, 1'b1);
        strobe(1'b0, 1'b1);
        check_outs({tag, "/p1"}, 2'd1, g, 1'b0, ~act, ~cas_act, ~we_act);
        strobe(1'b1, 1'b0);
        check_outs({tag, "/p2"}, 2'd2, g, 1'b0, ~act, ~cas_act, ~we_act);
        strobe(1'b0, 1'b1);
        check_outs({tag, "/p3"}, 2'd3, g, act, 1'b1, 1'b1, 1'b1);
        @(negedge mclk);
        check_eq({tag, "/ack_end"}, {7'd0, o_ack}, 8'd0);
    endtask

    initial begin
        bus16.render_req = 1'b0; bus16.slot_blank = 1'b0; bus16.fifo_req = 1'b0;
        bus16.fifo_we    = 1'b0; bus16.dma_req    = 1'b0;
        bus4.render_req  = 1'b0; bus4.slot_blank  = 1'b0; bus4.fifo_req  = 1'b0;
        bus4.fifo_we     = 1'b0; bus4.dma_req     = 1'b0;

        // Reset values on both instances.
        do_reset();
        sel4 = 1'b0;
        check_outs("rst16", 2'd3, 4'b0000, 1'b0, 1'b1, 1'b1, 1'b1);
        sel4 = 1'b1;
        check_outs("rst4", 2'd3, 4'b0000, 1'b0, 1'b1, 1'b1, 1'b1);

        // Period 4: three idle slots, refresh in slot 3, then render with refresh every 4th.
        run_slot("idle0", 4'b0000, 1'b0);
        run_slot("idle1", 4'b0000, 1'b0);
        run_slot("idle2", 4'b0000, 1'b0);
        run_slot("ref3",  4'b1000, 1'b0);
        bus4.render_req = 1'b1;
        for (int r = 0; r < 2; r++) begin
            run_slot($sformatf("rnd%0d_a", r), 4'b0100, 1'b0);
            run_slot($sformatf("rnd%0d_b", r), 4'b0100, 1'b0);
            run_slot($sformatf("rnd%0d_c", r), 4'b0100, 1'b0);
            run_slot($sformatf("ref%0d",   r), 4'b1000, 1'b0);
        end
        bus4.render_req = 1'b0;
        sel4 = 1'b0;

        // FIFO write after reset; a leading clk2 must not move the phase.
        do_reset();
        bus16.fifo_req = 1'b1;
        bus16.fifo_we  = 1'b1;
        strobe(1'b0, 1'b1);
        check_outs("clk2_first", 2'd3, 4'b0000, 1'b0, 1'b1, 1'b1, 1'b1);
        run_slot("fifo_wr", 4'b0010, 1'b1);
        bus16.fifo_req = 1'b0;
        run_slot("after_fifo", 4'b0000, 1'b0);

        // FIFO and DMA contending: round-robin starting with FIFO.
        do_reset();
        bus16.fifo_req = 1'b1;
        bus16.fifo_we  = 1'b0;
        bus16.dma_req  = 1'b1;
        run_slot("rr0", 4'b0010, 1'b0);
        run_slot("rr1", 4'b0001, 1'b1);
        run_slot("rr2", 4'b0010, 1'b0);
        run_slot("rr3", 4'b0001, 1'b1);
        bus16.dma_req = 1'b0;

        // Blanking masks render; FIFO read wins with we_n high. Then render unmasked.
        bus16.render_req = 1'b1;
        bus16.slot_blank = 1'b1;
        run_slot("blank_fifo_rd", 4'b0010, 1'b0);
        bus16.slot_blank = 1'b0;
        run_slot("render", 4'b0100, 1'b0);
        bus16.render_req = 1'b0;
        bus16.fifo_req   = 1'b0;

        // Reset in phase 1 of a DMA slot aborts it without ack.
        bus16.dma_req = 1'b1;
        strobe(1'b1, 1'b0);
        check_outs("dma_p0", 2'd0, 4'b0001, 1'b0, 1'b0, 1'b1, 1'b1);
        strobe(1'b0, 1'b1);
        check_outs("dma_p1", 2'd1, 4'b0001, 1'b0, 1'b0, 1'b0, 1'b0);
        rst = 1'b1;
        @(negedge mclk);
        rst = 1'b0;
        check_outs("mid_rst", 2'd3, 4'b0000, 1'b0, 1'b1, 1'b1, 1'b1);
        strobe(1'b0, 1'b1);
        check_outs("post_rst_clk2", 2'd3, 4'b0000, 1'b0, 1'b1, 1'b1, 1'b1);
        run_slot("dma_recover", 4'b0001, 1'b1);
        bus16.dma_req = 1'b0;

        $display("CHECKS %0d ERRORS %0d", check_cnt, error_cnt);
        $finish;
    end

endmodule
